// File: rtl/fb_rect_fill.sv
// fb_rect_fill -- solid rectangle fill engine in front of the frame-buffer write port.
//
// Takes one fill command (origin, size, 12-bit RGB colour), clips it to the
// FB_W x FB_H frame and streams one pixel write per wr_valid/wr_ready handshake
// in raster order. Addresses are linear pixel indices y*FB_W + x.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_x/y/w/h/color     rectangle origin, size and fill colour {R,G,B}
//   wr_valid/wr_ready     pixel write handshake to the frame buffer
//   wr_addr/wr_data       linear pixel index and colour of the pending write
//   busy                  engine is not idle
//   done                  one-cycle pulse when a command completes
module fb_rect_fill #(
   parameter int FB_W = 320,
   parameter int FB_H = 240
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [8:0]  cmd_x,
   input  logic [7:0]  cmd_y,
   input  logic [8:0]  cmd_w,
   input  logic [7:0]  cmd_h,
   input  logic [11:0] cmd_color,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [16:0] wr_addr,
   output logic [11:0] wr_data,
   output logic        busy,
   output logic        done
);

   typedef struct packed {
      logic [8:0]  x;
      logic [7:0]  y;
      logic [8:0]  w;
      logic [7:0]  h;
      logic [11:0] color;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

   state_t      state, state_nx;
   cmd_t        cmd_q;
   logic [9:0]  x_end, y_end;     // exclusive clipped bounds
   logic [8:0]  cur_x;
   logic [7:0]  cur_y;
   logic [16:0] row_base;        // cur_y*FB_W, tracked incrementally
   logic [9:0]  x_sum, y_sum, x_nxt, y_nxt;
   logic        empty, last_col, last_row;

   // 10-bit sums cannot overflow (511+511)
   assign x_sum = {1'b0, cmd_q.x} + {1'b0, cmd_q.w};
   assign y_sum = {2'b0, cmd_q.y} + {2'b0, cmd_q.h};
   assign empty = (cmd_q.w == 9'd0) || (cmd_q.h == 8'd0) ||
                  ({1'b0, cmd_q.x} >= 10'(FB_W)) || ({2'b0, cmd_q.y} >= 10'(FB_H));

   assign x_nxt    = {1'b0, cur_x} + 10'd1;
   assign y_nxt    = {2'b0, cur_y} + 10'd1;
   assign last_col = (x_nxt >= x_end);
   assign last_row = (y_nxt == y_end);

   // state register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (cmd_valid) state_nx = SETUP;
         SETUP: state_nx = empty ? DONE : RUN;
         RUN:   if (wr_ready && last_col && last_row) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // outputs; address/data are forced to zero outside RUN so the port is quiet when idle
   always_comb begin
      cmd_ready = 1'b0;
      wr_valid  = 1'b0;
      wr_addr   = 17'd0;
      wr_data   = 12'd0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         RUN: begin
            wr_valid = 1'b1;
            wr_addr  = row_base + {8'd0, cur_x};
            wr_data  = cmd_q.color;
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

   // datapath
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cmd_q    <= '0;
         x_end    <= '0;
         y_end    <= '0;
         cur_x    <= '0;
         cur_y    <= '0;
         row_base <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) cmd_q <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
            SETUP: begin
               x_end    <= (x_sum > 10'(FB_W)) ? 10'(FB_W) : x_sum;
               y_end    <= (y_sum > 10'(FB_H)) ? 10'(FB_H) : y_sum;
               cur_x    <= cmd_q.x;
               cur_y    <= cmd_q.y;
               row_base <= 17'(cmd_q.y) * 17'(FB_W);
            end
            RUN: if (wr_ready) begin
               if (!last_col) begin
                  cur_x <= x_nxt[8:0];
               end else begin
                  // wrap to next row with no bubble
                  cur_x    <= cmd_q.x;
                  cur_y    <= cur_y + 8'd1;
                  row_base <= row_base + 17'(FB_W);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_rect_fill.sv
module tb_fb_rect_fill;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [8:0]  cmd_x = '0;
   logic [7:0]  cmd_y = '0;
   logic [8:0]  cmd_w = '0;
   logic [7:0]  cmd_h = '0;
   logic [11:0] cmd_color = '0;
   logic        wr_valid;
   logic        wr_ready = 1'b1;
   logic [16:0] wr_addr;
   logic [11:0] wr_data;
   logic        busy;
   logic        done;

   fb_rect_fill #(.FB_W(320), .FB_H(240)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // monitor: inputs change at posedge+1, so the negedge sees a settled cycle
   logic [16:0] aq[$];
   logic [11:0] dq[$];
   int          acc_q[$];
   int          done_cnt = 0, done_cyc = 0, vcyc = 0, stall_err = 0, first_v = -1;
   logic        pend = 1'b0;
   logic [16:0] pa = '0;
   logic [11:0] pd = '0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
         if (wr_valid && wr_ready) begin
            aq.push_back(wr_addr);
            dq.push_back(wr_data);
         end
         if (wr_valid) begin
            vcyc++;
            if (first_v < 0) first_v = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (pend && (!wr_valid || wr_addr != pa || wr_data != pd)) stall_err++;
         pend = wr_valid && !wr_ready;
         pa   = wr_addr;
         pd   = wr_data;
      end else begin
         pend = 1'b0;
      end
   end

   function automatic logic [16:0] qa(input int i);
      return (aq.size() > i) ? aq[i] : 17'h1ffff;
   endfunction
   function automatic logic [11:0] qd(input int i);
      return (dq.size() > i) ? dq[i] : 12'hfff;
   endfunction

   function automatic void clr();
      aq.delete(); dq.delete(); acc_q.delete();
      vcyc = 0; stall_err = 0; first_v = -1;
   endfunction

   // Issues one command; wr_ready in cycle acc+2+i follows pat[i] for i<plen, else 1.
   // cmd_* are scrambled after acceptance to show they are ignored.
   task automatic run_cmd(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                          input logic [7:0] h, input logic [11:0] col, input logic [15:0] pat,
                          input int plen, input int budget, output int acc, output int lat);
      int d0, k;
      clr();
      d0 = done_cnt; acc = 0; lat = -1;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = col;
      wr_ready = 1'b1;
      k = 0;
      do begin @(negedge clk); #1; k++; end while (acc_q.size() == 0 && k < 16);
      if (acc_q.size() == 0) begin
         chk("accept_tmo", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      acc = acc_q[0];
      k = 0;
      while (done_cnt == d0 && k < budget) begin
         @(posedge clk); #1; k++;
         cmd_valid = 1'b0;
         cmd_x = 9'($urandom); cmd_y = 8'($urandom); cmd_w = 9'($urandom);
         cmd_h = 8'($urandom); cmd_color = 12'($urandom);
         wr_ready = (k >= 2 && k - 2 < plen) ? pat[k-2] : 1'b1;
         @(negedge clk); #1;
      end
      chk("done_seen", done_cnt - d0, 1);
      lat = done_cyc - acc;
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("idle_ready", {31'd0, cmd_ready}, 1);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("one_done", done_cnt - d0, 1);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int acc, lat, bad, d0, k;
      logic [16:0] exp_a[6];
      logic [16:0] clip_a[4];
      logic [16:0] bp_a[4];

      // reset state
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, cmd_ready}, 1);
      chk("rst_valid", {31'd0, wr_valid}, 0);
      chk("rst_addr", {15'd0, wr_addr}, 0);
      chk("rst_data", {20'd0, wr_data}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // full-screen clear
      run_cmd(9'd0, 8'd0, 9'd320, 8'd240, 12'h000, 16'h0, 0, 80000, acc, lat);
      chk("fs_count", aq.size(), 76800);
      bad = 0;
      for (int i = 0; i < aq.size(); i++)
         if (aq[i] != 17'(i) || dq[i] != 12'h000) bad++;
      chk("fs_seq", bad, 0);
      chk("fs_done_lat", lat, 76802);
      chk("fs_vcyc", vcyc, 76800);

      // small box
      exp_a = '{17'd1610, 17'd1611, 17'd1612, 17'd1930, 17'd1931, 17'd1932};
      run_cmd(9'd10, 8'd5, 9'd3, 8'd2, 12'hF0F, 16'h0, 0, 100, acc, lat);
      chk("box_count", aq.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("box_a%0d", i), {15'd0, qa(i)}, {15'd0, exp_a[i]});
         chk($sformatf("box_d%0d", i), {20'd0, qd(i)}, 32'hF0F);
      end
      chk("box_first_v", first_v - acc, 2);
      chk("box_done_lat", lat, 8);

      // clip at bottom-right corner
      clip_a = '{17'd76478, 17'd76479, 17'd76798, 17'd76799};
      run_cmd(9'd318, 8'd238, 9'd5, 8'd5, 12'h5A5, 16'h0, 0, 100, acc, lat);
      chk("clip_count", aq.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("clip_a%0d", i), {15'd0, qa(i)}, {15'd0, clip_a[i]});
      chk("clip_done_lat", lat, 6);

      // empty commands
      run_cmd(9'd320, 8'd10, 9'd4, 8'd4, 12'h123, 16'h0, 0, 100, acc, lat);
      chk("offx_count", aq.size(), 0);
      chk("offx_vcyc", vcyc, 0);
      chk("offx_lat", lat, 2);
      run_cmd(9'd20, 8'd10, 9'd0, 8'd4, 12'h123, 16'h0, 0, 100, acc, lat);
      chk("w0_count", aq.size(), 0);
      chk("w0_vcyc", vcyc, 0);
      chk("w0_lat", lat, 2);

      // backpressure, wr_ready = 1,0,0,1,0,1,1 (pat bit i is cycle i)
      bp_a = '{17'd0, 17'd1, 17'd320, 17'd321};
      run_cmd(9'd0, 8'd0, 9'd2, 8'd2, 12'h7E1, 16'b110_1001, 7, 100, acc, lat);
      chk("bp_count", aq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bp_a%0d", i), {15'd0, qa(i)}, {15'd0, bp_a[i]});
         chk($sformatf("bp_d%0d", i), {20'd0, qd(i)}, 32'h7E1);
      end
      chk("bp_stall_stable", stall_err, 0);
      chk("bp_vcyc", vcyc, 7);
      chk("bp_done_lat", lat, 9);

      // reset mid-fill after 7 accepted writes
      clr();
      d0 = done_cnt;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_x = 9'd0; cmd_y = 8'd0; cmd_w = 9'd20; cmd_h = 8'd20;
      cmd_color = 12'h321; wr_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      k = 0;
      while (aq.size() < 7 && k < 100) begin @(negedge clk); #1; k++; end
      chk("mid_reach7", aq.size(), 7);
      @(posedge clk); #1;
      reset_n = 1'b0; wr_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("mid_valid", {31'd0, wr_valid}, 0);
      chk("mid_busy", {31'd0, busy}, 0);
      @(posedge clk); #1;
      reset_n = 1'b1; wr_ready = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      chk("mid_no_more_wr", aq.size(), 7);
      chk("mid_no_done", done_cnt - d0, 0);
      run_cmd(9'd5, 8'd2, 9'd1, 8'd1, 12'hABC, 16'h0, 0, 100, acc, lat);
      chk("after_count", aq.size(), 1);
      chk("after_addr", {15'd0, qa(0)}, 645);
      chk("after_data", {20'd0, qd(0)}, 32'hABC);
      chk("after_lat", lat, 3);

      // back-to-back with cmd_valid held high
      clr();
      d0 = done_cnt;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_x = 9'd0; cmd_y = 8'd1; cmd_w = 9'd2; cmd_h = 8'd1;
      cmd_color = 12'h111; wr_ready = 1'b1;
      @(negedge clk); #1;
      @(posedge clk); #1;
      cmd_x = 9'd3; cmd_y = 8'd0; cmd_w = 9'd1; cmd_h = 8'd1; cmd_color = 12'h222;
      k = 0;
      while (acc_q.size() < 2 && k < 50) begin @(negedge clk); #1; k++; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      k = 0;
      while (done_cnt < d0 + 2 && k < 50) begin @(negedge clk); #1; k++; end
      chk("b2b_accepts", acc_q.size(), 2);
      if (acc_q.size() == 2) chk("b2b_spacing", acc_q[1] - acc_q[0], 5);
      chk("b2b_dones", done_cnt - d0, 2);
      chk("b2b_count", aq.size(), 3);
      chk("b2b_a0", {15'd0, qa(0)}, 320);
      chk("b2b_a1", {15'd0, qa(1)}, 321);
      chk("b2b_a2", {15'd0, qa(2)}, 3);
      chk("b2b_d0", {20'd0, qd(0)}, 32'h111);
      chk("b2b_d1", {20'd0, qd(1)}, 32'h111);
      chk("b2b_d2", {20'd0, qd(2)}, 32'h222);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fb_rect_fill.md
# fb_rect_fill

Hardware rectangle-fill engine placed directly upstream of the frame-buffer write port. It accepts one fill command at a time: origin, size and a 12-bit RGB colour. It clips the rectangle to the FB_W x FB_H frame and emits one pixel write per accepted handshake, in raster order. This lets the CPU clear the screen or draw solid boxes without issuing a write per pixel. Output addresses are linear pixel indices (y*FB_W + x) matching the 320x240, 12-bit frame-buffer layout.

## Interface
- FB_W, 320, frame width in pixels
- FB_H, 240, frame height in pixels
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command (high only in IDLE)
- cmd_x  in  9  left column
- cmd_y  in  8  top row
- cmd_w  in  9  width in pixels
- cmd_h  in  8  height in pixels
- cmd_color  in  12  fill colour {R[3:0],G[3:0],B[3:0]}
- wr_valid  out  1  pixel write pending
- wr_ready  in  1  downstream accepts write this cycle
- wr_addr  out  17  linear pixel index
- wr_data  out  12  pixel colour
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at completion of each command

## Operation
- States: IDLE, SETUP, RUN, DONE.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch all cmd_* fields, go to SETUP.
- SETUP (1 cycle)
  - Compute x_end = min(cmd_x+cmd_w, FB_W) and y_end = min(cmd_y+cmd_h, FB_H) with 10-bit sums; no overflow is possible (max 511+511).
  - Empty if cmd_w==0, cmd_h==0, cmd_x>=FB_W or cmd_y>=FB_H. Empty -> DONE with no writes.
  - Otherwise: cur_x=cmd_x, cur_y=cmd_y, row_base=cmd_y*FB_W (17 bits; max 239*320=76480). Go to RUN.
- RUN
  - wr_valid=1, wr_addr=row_base+cur_x, wr_data=latched colour.
  - On wr_ready: if cur_x+1<x_end, increment cur_x. Else cur_x=cmd_x, cur_y++ and row_base+=FB_W. If that was the last row (cur_y+1==y_end), go to DONE.
  - Without wr_ready, wr_valid/wr_addr/wr_data hold stable. wr_valid never drops until the write is accepted.
- DONE (1 cycle): done=1, then IDLE.
- Writes per command = (x_end-cmd_x)*(y_end-cmd_y). Clipped pixels are never emitted. wr_addr is always < FB_W*FB_H.
- cmd_* inputs are ignored outside IDLE.

## Timing
- Reset values: state=IDLE, cmd_ready=1, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0.
- Reset asserted mid-command aborts it:
  - wr_valid falls at that edge.
  - No done pulse.
  - No further writes after reset releases.
- Command accepted at edge N: busy=1 and cmd_ready=0 from N+1 (SETUP). First wr_valid in cycle N+2.
- Throughput: one write per cycle while wr_ready is held high. No bubbles between rows.
- Last write accepted at edge M: wr_valid=0 and done=1 in cycle M+1. cmd_ready=1 and busy=0 in cycle M+2.
- Empty command accepted at edge N: done=1 in cycle N+2, zero wr_valid cycles.
- A command cannot be accepted in the same cycle as done. Minimum command-to-command spacing is one IDLE cycle.

## Test plan
- Reset, then x=0,y=0,w=FB_W,h=FB_H, colour 0x000, wr_ready=1:
  - 76800 writes, addresses 0..76799 consecutive.
  - done exactly at cycle N+2+76800.
- x=10,y=5,w=3,h=2, colour 0xF0F:
  - Addresses 1610,1611,1612,1930,1931,1932, all with data 0xF0F.
  - Single done pulse.
- Clipping, x=318,y=238,w=5,h=5:
  - Addresses 76478,76479,76798,76799 only.
  - Command x=320,w=4 -> zero writes, done at N+2.
  - Command w=0 -> same.
- Backpressure:
  - 2x2 fill with wr_ready toggling 1,0,0,1,0,1,1: addr/data stable while stalled, exactly 4 accepted writes in raster order.
- Reset mid-fill:
  - Assert reset_n=0 after 7 writes of a 20x20 fill: wr_valid=0 and busy=0 next cycle, no done.
  - A new 1x1 command afterwards completes normally.
- Back-to-back:
  - cmd_valid held high with two commands: second accepted only when cmd_ready returns, in cycle M+2.
  - cmd_* changes during RUN do not affect the first fill.
